// File: rtl/pipelined_add_sub_pkg.sv
// Shared definitions for the pipelined add/sub unit: operation encodings and
// bit positions of the NZCV flags when packed into a status word.
package pipelined_add_sub_pkg;

   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } mode_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

// File: rtl/pipelined_add_sub_slice.sv
// One combinational carry-chained slice of the pipelined adder; returns the
// slice sum, its carry-out and the carry into its own MSB (for overflow).
module add_sub_slice
   import pipelined_add_sub_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         cmsb
);

   logic [W:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   assign sum   = total[W-1:0];
   assign cout  = total[W];
   // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly
   assign cmsb  = a[W-1] ^ b[W-1] ^ total[W-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake and
// NZCV flags. Define ADDSUB_SATURATE_EN to clamp overflowing results.
module pipelined_add_sub
   import pipelined_add_sub_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v
);

   localparam int SW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;

   typedef struct packed {
      logic             vld;
      logic             sel;
      logic [WIDTH-1:0] res;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             carry;
      logic             cmsb;
   } stage_t;

   stage_t        head;
   stage_t        cur     [STAGES];
   stage_t        nxt     [STAGES];
   stage_t        stage_q [STAGES];
   stage_t        last_fixed;
   logic [SW-1:0] sum     [STAGES];
   logic          cout    [STAGES];
   logic          cmsb    [STAGES];
   logic [3:0]    flags_d;
   logic [3:0]    flags_q;
   logic          adv;

   if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
      $error("pipelined_add_sub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   function automatic stage_t merge(input stage_t c, input logic [SW-1:0] s,
                                    input logic co, input logic cm, input int k);
      stage_t r;
      r = c;
      r.res[k*SW +: SW] = s;
      r.carry = co;
      r.cmsb  = cm;
      return r;
   endfunction

   // Subtract enters as A + ~B + 1: B inverted once here, carry-in of slice 0 is sel.
   always_comb begin
      head       = '0;
      head.vld   = in_valid;
      head.sel   = sel;
      head.a     = A;
      head.b     = B ^ {WIDTH{sel}};
      head.carry = (sel == SUB);
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      if (k == 0) begin : g_first
         assign cur[k] = head;
      end else begin : g_rest
         assign cur[k] = stage_q[k-1];
      end

      add_sub_slice #(.W(SW)) u_slice (
         .a    (cur[k].a[k*SW +: SW]),
         .b    (cur[k].b[k*SW +: SW]),
         .cin  (cur[k].carry),
         .sum  (sum[k]),
         .cout (cout[k]),
         .cmsb (cmsb[k])
      );

      assign nxt[k] = merge(cur[k], sum[k], cout[k], cmsb[k], k);
   end

   // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      last_fixed      = nxt[LAST];
      flags_d         = '0;
      flags_d[FLAG_C] = nxt[LAST].carry;
      flags_d[FLAG_V] = nxt[LAST].carry ^ nxt[LAST].cmsb;
`ifdef ADDSUB_SATURATE_EN
      if (flags_d[FLAG_V]) begin
         last_fixed.res = cur[LAST].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
      flags_d[FLAG_N] = last_fixed.res[WIDTH-1];
      flags_d[FLAG_Z] = (last_fixed.res == '0);
   end

   assign adv      = !stage_q[LAST].vld || out_ready;
   assign in_ready = adv;

   // NOTE: sequential state uses non-blocking assignments so all stages shift on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: data fields are cleared along with the valid bits so S and the flags read zero in reset.
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
         flags_q <= '0;
      end else if (adv) begin
         for (int k = 0; k < LAST; k++) begin
            stage_q[k] <= nxt[k];
         end
         stage_q[LAST] <= last_fixed;
         flags_q       <= flags_d;
      end
   end

   assign out_valid = stage_q[LAST].vld;
   assign S         = stage_q[LAST].res;
   assign flag_n    = flags_q[FLAG_N];
   assign flag_z    = flags_q[FLAG_Z];
   assign flag_c    = flags_q[FLAG_C];
   assign flag_v    = flags_q[FLAG_V];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed self-checking bench for pipelined_add_sub (WIDTH=32, STAGES=4);
// honours ADDSUB_SATURATE_EN when computing expected results.
module tb_pipelined_add_sub;
   import pipelined_add_sub_pkg::*;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [31:0] exp_s;
      logic [3:0]  exp_f;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  A;
   logic [WIDTH-1:0]  B;
   logic              sel;
   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  S;
   logic              flag_n, flag_z, flag_c, flag_v;
   logic [3:0]        flags;

   int checks = 0;
   int errors = 0;

   assign flags = {flag_n, flag_z, flag_c, flag_v};

   always #5 clk = ~clk;

   pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .S         (S),
      .flag_n    (flag_n),
      .flag_z    (flag_z),
      .flag_c    (flag_c),
      .flag_v    (flag_v)
   );

   // Reference result {N,Z,C,V,S} from plain integer arithmetic.
   function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [32:0] full;
      logic [31:0] r;
      logic        c, v;
      if (!s) begin
         full = {1'b0, a} + {1'b0, b};
         r    = full[31:0];
         c    = full[32];
         v    = (a[31] == b[31]) && (r[31] != a[31]);
      end else begin
         r = a - b;
         c = (a >= b);
         v = (a[31] != b[31]) && (r[31] != a[31]);
      end
`ifdef ADDSUB_SATURATE_EN
      if (v) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return {r[31], (r == 32'h0), c, v, r};
   endfunction

   // Drives one beat on an idle pipeline and returns the result and its latency in edges.
   task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] res, output logic [3:0] fl, output int lat);
      @(negedge clk);
      A = a; B = b; sel = s; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      res = S;
      fl  = flags;
   endtask

   task automatic check_vectors(input string name, input vec_t v[]);
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
      foreach (v[i]) begin
         run_one(v[i].a, v[i].b, v[i].s, res, fl, lat);
         checks++;
         if (res !== v[i].exp_s || fl !== v[i].exp_f || lat != STAGES) begin
            errors++;
            $display("FAIL %s[%0d]: got S=%h NZCV=%b latency=%0d, expected S=%h NZCV=%b latency=%0d",
                     name, i, res, fl, lat, v[i].exp_s, v[i].exp_f, STAGES);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; sel = ADD;
      #12;
      checks++;
      if (out_valid !== 1'b0 || S !== 32'h0 || flags !== 4'b0000) begin
         errors++;
         $display("FAIL reset_state: got out_valid=%b S=%h NZCV=%b, expected 0 00000000 0000",
                  out_valid, S, flags);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
      end
   endtask

   task automatic test_add();
      vec_t v[] = '{'{32'd5, 32'd7, ADD, 32'd12, 4'b0000}};
      check_vectors("add", v);
   endtask

   task automatic test_subtract();
      vec_t v[] = '{'{32'd3, 32'd3, SUB, 32'd0,        4'b0110},
                    '{32'd0, 32'd1, SUB, 32'hFFFF_FFFF, 4'b1000}};
      check_vectors("subtract", v);
   endtask

   task automatic test_carry_chain();
      vec_t v[] = '{'{32'h0000_00FF, 32'd1, ADD, 32'h0000_0100, 4'b0000},
                    '{32'h00FF_FFFF, 32'd1, ADD, 32'h0100_0000, 4'b0000},
                    '{32'hFFFF_FFFF, 32'd1, ADD, 32'h0000_0000, 4'b0110},
                    '{32'h0000_0100, 32'd1, SUB, 32'h0000_00FF, 4'b0010}};
      check_vectors("carry_chain", v);
   endtask

   task automatic test_overflow();
`ifdef ADDSUB_SATURATE_EN
      vec_t v[] = '{'{32'h7FFF_FFFF, 32'd1,        ADD, 32'h7FFF_FFFF, 4'b0001},
                    '{32'h8000_0000, 32'd1,        SUB, 32'h8000_0000, 4'b1011},
                    '{32'h8000_0000, 32'h8000_0000, ADD, 32'h8000_0000, 4'b1011}};
`else
      vec_t v[] = '{'{32'h7FFF_FFFF, 32'd1,        ADD, 32'h8000_0000, 4'b1001},
                    '{32'h8000_0000, 32'd1,        SUB, 32'h7FFF_FFFF, 4'b0011},
                    '{32'h8000_0000, 32'h8000_0000, ADD, 32'h0000_0000, 4'b0111}};
`endif
      check_vectors("overflow", v);
   endtask

   task automatic test_back_to_back();
      logic [35:0] expq[$];
      logic [35:0] e;
      logic [31:0] va[8];
      logic [31:0] vb[8];
      logic        vs[8];
      logic        held = 1'b0;
      logic [31:0] hs = '0;
      logic [3:0]  hf = '0;
      int          sent = 0, rcvd = 0, cyc = 0, held_cycles = 0;
      for (int i = 0; i < 8; i++) begin
         va[i] = $urandom;
         vb[i] = $urandom;
         vs[i] = i[0];
      end
      while (rcvd < 8 && cyc < 60) begin
         @(negedge clk);
         out_ready = !(cyc >= 5 && cyc <= 7);
         in_valid  = (sent < 8);
         if (sent < 8) begin
            A = va[sent]; B = vb[sent]; sel = vs[sent];
         end
         #1;
         if (held) begin
            checks++;
            if (out_valid !== 1'b1 || S !== hs || flags !== hf) begin
               errors++;
               $display("FAIL hold_stable: got valid=%b S=%h NZCV=%b, expected 1 %h %b",
                        out_valid, S, flags, hs, hf);
            end
         end
         checks++;
         if (in_ready !== (!out_valid || out_ready)) begin
            errors++;
            $display("FAIL in_ready_backpressure: got %b with out_valid=%b out_ready=%b",
                     in_ready, out_valid, out_ready);
         end
         if (out_valid && out_ready) begin
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL stream_extra: got unexpected S=%h, expected no result", S);
            end else begin
               e = expq.pop_front();
               if ({flags, S} !== e) begin
                  errors++;
                  $display("FAIL stream_result[%0d]: got S=%h NZCV=%b, expected S=%h NZCV=%b",
                           rcvd, S, flags, e[31:0], e[35:32]);
               end
            end
            rcvd++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(model(A, B, sel));
            sent++;
         end
         held = out_valid && !out_ready;
         if (held) held_cycles++;
         hs = S;
         hf = flags;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (rcvd != 8) begin
         errors++;
         $display("FAIL stream_count: got %0d results, expected 8", rcvd);
      end
      checks++;
      if (held_cycles != 3) begin
         errors++;
         $display("FAIL stream_stall: got %0d held cycles, expected 3", held_cycles);
      end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
      int          stale = 0;
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         A = i + 1; B = 32'd1; sel = ADD;
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL midflight_valid: got out_valid=%b, expected 1", out_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || S !== 32'h0 || flags !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset: got out_valid=%b S=%h NZCV=%b, expected 0 00000000 0000",
                  out_valid, S, flags);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      checks++;
      if (stale != 0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_flush: got %0d stale valid cycles in_ready=%b, expected 0 and 1",
                  stale, in_ready);
      end
      run_one(32'd10, 32'd4, SUB, res, fl, lat);
      checks++;
      if (res !== 32'd6 || fl !== 4'b0010 || lat != STAGES) begin
         errors++;
         $display("FAIL after_reset: got S=%h NZCV=%b latency=%0d, expected S=00000006 NZCV=0010 latency=%0d",
                  res, fl, lat, STAGES);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_subtract();
      test_carry_chain();
      test_overflow();
      test_back_to_back();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time limit, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the team's combinational 32-bit add/sub unit.
- Splits the WIDTH-bit operation into STAGES carry-chained slices, one slice per cycle, so the carry path is cut for high clock rates.
- Adds a valid/ready streaming handshake with backpressure and NZCV status flags.
- Sits between operand-fetch and writeback in the lab datapath.

Parameters:
- WIDTH, 32: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline slices; 1 <= STAGES <= WIDTH. Latency equals STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  the operand beat is valid.
- in_ready  output  1  the block accepts a beat this cycle.
- A  input  WIDTH  operand A, two's complement.
- B  input  WIDTH  operand B, two's complement.
- sel  input  1  0 = add (A+B); 1 = subtract (A-B).
- out_valid  output  1  the result beat is valid.
- out_ready  input  1  the downstream block accepts the result.
- S  output  WIDTH  result.
- flag_n  output  1  negative: S[WIDTH-1].
- flag_z  output  1  zero: S == 0.
- flag_c  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- flag_v  output  1  signed overflow.

Behaviour:
- Reset: when rst rises, every stage valid bit clears immediately, without waiting for a clock edge.
  - out_valid=0, S=0, all flags=0.
  - in_ready=1 once rst is deasserted.
- Subtract is computed as A + ~B + 1: the B slice is inverted and the carry-in of slice 0 is sel.
- Slice k (k=0..STAGES-1) adds bits [(k+1)*W/STAGES-1 : k*W/STAGES] using the carry registered from slice k-1.
- Each stage register holds:
  - the valid bit;
  - sel;
  - the completed low result bits;
  - the not-yet-consumed upper A and B bits (B already inverted);
  - the running carry;
  - the carry into the MSB, needed for V.
- Global advance: adv = !out_valid || out_ready. All stages shift together when adv=1 and hold when adv=0.
- in_ready = adv, driven combinationally. A beat is accepted when in_valid && in_ready.
- Bubbles: if in_valid=0 while adv=1, an invalid bubble enters stage 0. Bubbles propagate and are never presented as output.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES-1, assuming no stall.
- Throughput: one result per cycle.
- Output hold: while out_valid=1 && out_ready=0, S and all flags stay stable. No beat is dropped or reordered.
- Simultaneous accept and output: allowed in the same cycle.
- Flag rules:
  - flag_c = final carry.
  - flag_v = carry_into_MSB XOR carry_out_of_MSB.
  - flag_n and flag_z are computed from the final presented S, i.e. after saturation when that feature is enabled.
- Width rule: S is the result modulo 2^WIDTH. No sign extension.
- STAGES=1: the block degenerates to a single registered adder with latency 1.
- Reset during operation: all in-flight beats are discarded and none emerge after reset is released.

Optional Feature:
- Macro ADDSUB_SATURATE_EN.
- When defined: if flag_v=1, S is clamped to the signed limit.
  - Positive overflow (A[MSB]=0): S = 0x7F..F.
  - Negative overflow: S = 0x80..0.
  - flag_v still reports 1.
  - flag_c remains the raw carry.
  - Clamping happens in the final stage and adds no latency.
- When undefined: S is the plain wrapping result and no clamp logic is generated.

Decomposition:
- Shared package/header holds:
  - the mode encodings ADD=1'b0 and SUB=1'b1;
  - the flag bit-position constants N=3, Z=2, C=1, V=0, used when the flags are packed into a status word downstream.
- One sub-module, add_sub_slice:
  - combinational W/STAGES-bit adder with carry-in;
  - outputs the sum slice, carry-out, and carry into its own MSB;
  - instantiated STAGES times by a generate loop.
  - The pipeline registers stay in pipelined_add_sub.

Test Plan (WIDTH=32, STAGES=4):
1. Add 5 + 7, out_ready=1 → S=12, NZCV=0000, out_valid rises 4 cycles after acceptance.
2. Subtract 3 - 3 → S=0, Z=1, C=1, N=0, V=0.
3. Subtract 0 - 1 → S=0xFFFFFFFF, N=1, C=0, V=0.
4. Overflow, add 0x7FFFFFFF + 1 → S=0x80000000, N=1, V=1. With ADDSUB_SATURATE_EN → S=0x7FFFFFFF, N=0, V=1.
5. Backpressure: stream 8 back-to-back random beats and hold out_ready=0 for 3 cycles mid-stream.
   - in_ready drops whenever out_valid=1 and out_ready=0.
   - Outputs stay stable while held.
   - All 8 results match the model, in order, with none lost.
6. Reset mid-flight: accept 3 beats, assert rst between clock edges.
   - out_valid=0 immediately.
   - After release, no stale results appear.
   - The next beat, 10 - 4, yields S=6 after 4 cycles.
